// File: rtl/text_console_ctrl.sv
// Console controller: byte stream in, cursor/attribute state, text RAM writes.
// Ports: clk_pix, reset (async low), in_valid/in_data/in_ready, ram_ce/ram_addr/ram_data, cur_col/cur_row, busy.
module text_console_ctrl #(
  parameter int          COLS         = 100,
  parameter int          ROWS         = 30,
  parameter logic [7:0]  DEFAULT_ATTR = 8'hF0
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        ram_ce,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_data,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);

  localparam logic [11:0] COLS12   = 12'(COLS);
  localparam logic [11:0] CELLS12  = 12'(ROWS * COLS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    ESC,
    CLR_ROW
  } state_t;

  state_t      r_state, w_state;
  logic [6:0]  r_col, w_col;
  logic [4:0]  r_row, w_row;
  logic [11:0] r_base, w_base;
  logic [11:0] r_cnt, w_cnt;
  logic [7:0]  r_attr, w_attr;
  logic        r_ce, w_ce;
  logic [11:0] r_addr, w_addr;
  logic [15:0] r_data, w_data;
  logic        r_ready, w_ready;
  logic        r_busy, w_busy;

  logic        w_acc;
  logic        w_print;
  logic        w_wrap;
  logic [4:0]  w_nl_row;
  logic [11:0] w_nl_base;
  logic [15:0] w_blank;

  assign w_acc     = in_valid && r_ready;
  assign w_print   = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign w_wrap    = (r_row == LAST_ROW);
  assign w_nl_row  = w_wrap ? 5'd0 : r_row + 5'd1;
  assign w_nl_base = w_wrap ? 12'd0 : r_base + COLS12;
  assign w_blank   = {r_attr, 8'h20};

  always_comb begin
    w_state = r_state;
    w_col   = r_col;
    w_row   = r_row;
    w_base  = r_base;
    w_cnt   = r_cnt;
    w_attr  = r_attr;
    w_ce    = 1'b0;
    w_addr  = r_addr;
    w_data  = r_data;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (w_print) begin
            w_ce   = 1'b1;
            w_addr = r_base + {5'd0, r_col};
            w_data = {r_attr, 1'b0, in_data[6:0]};
            if (r_col < LAST_COL) begin
              w_col = r_col + 7'd1;
            end else begin
              // autowrap: cell write goes out now, row clear follows
              w_col   = 7'd0;
              w_row   = w_nl_row;
              w_base  = w_nl_base;
              w_cnt   = 12'd0;
              w_state = CLR_ROW;
            end
          end else begin
            case (in_data)
              8'h0A: begin
                // first clear write is issued on the accepting edge
                w_col   = 7'd0;
                w_row   = w_nl_row;
                w_base  = w_nl_base;
                w_ce    = 1'b1;
                w_addr  = w_nl_base;
                w_data  = w_blank;
                w_cnt   = 12'd1;
                w_state = CLR_ROW;
              end
              8'h0D: w_col = 7'd0;
              8'h08: begin
                if (r_col != 7'd0) w_col = r_col - 7'd1;
              end
              8'h0C: begin
                w_ce    = 1'b1;
                w_addr  = 12'd0;
                w_data  = w_blank;
                w_cnt   = 12'd1;
                w_state = CLR_ALL;
              end
              8'h1B: w_state = ESC;
              default: ;
            endcase
          end
        end
      end
      ESC: begin
        if (w_acc) begin
          w_attr  = in_data;
          w_state = IDLE;
        end
      end
      CLR_ROW: begin
        // one idle edge after the last write keeps in_ready low through it
        if (r_cnt == COLS12) begin
          w_state = IDLE;
        end else begin
          w_ce   = 1'b1;
          w_addr = r_base + r_cnt;
          w_data = w_blank;
          w_cnt  = r_cnt + 12'd1;
        end
      end
      CLR_ALL: begin
        if (r_cnt == CELLS12) begin
          w_state = IDLE;
          w_col   = 7'd0;
          w_row   = 5'd0;
          w_base  = 12'd0;
        end else begin
          w_ce   = 1'b1;
          w_addr = r_cnt;
          w_data = w_blank;
          w_cnt  = r_cnt + 12'd1;
        end
      end
    endcase
    w_ready = (w_state == IDLE) || (w_state == ESC);
    w_busy  = (w_state == CLR_ALL) || (w_state == CLR_ROW);
  end

  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      r_state <= CLR_ALL;
      r_col   <= 7'd0;
      r_row   <= 5'd0;
      r_base  <= 12'd0;
      r_cnt   <= 12'd0;
      r_attr  <= DEFAULT_ATTR;
      r_ce    <= 1'b0;
      r_addr  <= 12'd0;
      r_data  <= 16'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_col   <= w_col;
      r_row   <= w_row;
      r_base  <= w_base;
      r_cnt   <= w_cnt;
      r_attr  <= w_attr;
      r_ce    <= w_ce;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_ready <= w_ready;
      r_busy  <= w_busy;
    end
  end

  assign in_ready = r_ready;
  assign ram_ce   = r_ce;
  assign ram_addr = r_addr;
  assign ram_data = r_data;
  assign cur_col  = r_col;
  assign cur_row  = r_row;
  assign busy     = r_busy;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl.
// Table-driven byte vectors plus hand sequences for clears, autowrap and reset.
module tb_text_console_ctrl;

  logic        clk_pix;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_ce;
  logic [11:0] ram_addr;
  logic [15:0] ram_data;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  int checks = 0;
  int errors = 0;

  text_console_ctrl dut (
    .clk_pix  (clk_pix),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ram_ce   (ram_ce),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ce;
    logic [11:0] a;
    logic [15:0] q;
    logic [6:0]  col;
    logic        rdy;
  } vec_t;

  vec_t tbl [22];

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Walks a run of clear writes starting in the current cycle.
  task automatic check_clear(input string nm, input int base,
                             input int n, input logic [15:0] d);
    int k;
    int bad;
    k = 0;
    bad = 0;
    while (ram_ce && k < n + 10) begin
      if (ram_addr != 12'(base + k) || ram_data != d || in_ready)
        bad++;
      k++;
      step();
    end
    chk({nm, "_count"}, k, n);
    chk({nm, "_content"}, bad, 0);
    chk({nm, "_ready_after"}, {in_ready, busy}, 2'b10);
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int bad;
    tbl[0]  = '{1'b1, 8'h41, 1'b1, 12'd0, 16'hF041, 7'd1, 1'b1};
    tbl[1]  = '{1'b1, 8'h42, 1'b1, 12'd1, 16'hF042, 7'd2, 1'b1};
    tbl[2]  = '{1'b1, 8'h1B, 1'b0, 12'd1, 16'hF042, 7'd2, 1'b1};
    tbl[3]  = '{1'b1, 8'h1E, 1'b0, 12'd1, 16'hF042, 7'd2, 1'b1};
    tbl[4]  = '{1'b1, 8'h78, 1'b1, 12'd2, 16'h1E78, 7'd3, 1'b1};
    tbl[5]  = '{1'b1, 8'h07, 1'b0, 12'd2, 16'h1E78, 7'd3, 1'b1};
    tbl[6]  = '{1'b1, 8'h0D, 1'b0, 12'd2, 16'h1E78, 7'd0, 1'b1};
    tbl[7]  = '{1'b1, 8'h08, 1'b0, 12'd2, 16'h1E78, 7'd0, 1'b1};
    tbl[8]  = '{1'b1, 8'h43, 1'b1, 12'd0, 16'h1E43, 7'd1, 1'b1};
    tbl[9]  = '{1'b1, 8'h44, 1'b1, 12'd1, 16'h1E44, 7'd2, 1'b1};
    tbl[10] = '{1'b1, 8'h08, 1'b0, 12'd1, 16'h1E44, 7'd1, 1'b1};
    tbl[11] = '{1'b0, 8'h41, 1'b0, 12'd1, 16'h1E44, 7'd1, 1'b1};
    tbl[12] = '{1'b1, 8'h1B, 1'b0, 12'd1, 16'h1E44, 7'd1, 1'b1};
    tbl[13] = '{1'b1, 8'h0C, 1'b0, 12'd1, 16'h1E44, 7'd1, 1'b1};
    tbl[14] = '{1'b1, 8'h41, 1'b1, 12'd1, 16'h0C41, 7'd2, 1'b1};
    tbl[15] = '{1'b1, 8'h1B, 1'b0, 12'd1, 16'h0C41, 7'd2, 1'b1};
    tbl[16] = '{1'b1, 8'hF0, 1'b0, 12'd1, 16'h0C41, 7'd2, 1'b1};
    tbl[17] = '{1'b1, 8'h61, 1'b1, 12'd2, 16'hF061, 7'd3, 1'b1};
    tbl[18] = '{1'b1, 8'h62, 1'b1, 12'd3, 16'hF062, 7'd4, 1'b1};
    tbl[19] = '{1'b1, 8'h63, 1'b1, 12'd4, 16'hF063, 7'd5, 1'b1};
    tbl[20] = '{1'b1, 8'h0D, 1'b0, 12'd4, 16'hF063, 7'd0, 1'b1};
    tbl[21] = '{1'b1, 8'h08, 1'b0, 12'd4, 16'hF063, 7'd0, 1'b1};

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) step();
    chk("rst_ce", ram_ce, 1'b0);
    chk("rst_addr", ram_addr, 12'd0);
    chk("rst_data", ram_data, 16'd0);
    chk("rst_cursor", {cur_row, cur_col}, 12'd0);
    chk("rst_ready_busy", {in_ready, busy}, 2'b01);

    reset = 1'b1;
    step();
    check_clear("init_clear", 0, 3000, 16'hF020);
    chk("init_cursor", {cur_row, cur_col}, 12'd0);

    for (int i = 0; i < 22; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      step();
      chk($sformatf("vec%0d_ce", i), ram_ce, tbl[i].ce);
      chk($sformatf("vec%0d_addr", i), ram_addr, tbl[i].a);
      chk($sformatf("vec%0d_data", i), ram_data, tbl[i].q);
      chk($sformatf("vec%0d_col", i), cur_col, tbl[i].col);
      chk($sformatf("vec%0d_row", i), cur_row, 5'd0);
      chk($sformatf("vec%0d_ready", i), in_ready, tbl[i].rdy);
    end
    in_valid = 1'b0;

    for (int r = 1; r < 30; r++) begin
      send(8'h0A);
      chk($sformatf("lf%0d_cursor", r), {cur_row, cur_col},
          {5'(r), 7'd0});
      check_clear($sformatf("lf%0d_clear", r), r * 100, 100, 16'hF020);
    end

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h61;
      step();
      if (!ram_ce || ram_addr != 12'(2900 + i) || ram_data != 16'hF061)
        bad++;
    end
    in_valid = 1'b0;
    chk("wrap_cells", bad, 0);
    chk("wrap_last_addr", ram_addr, 12'd2999);
    chk("wrap_cursor", {cur_row, cur_col}, 12'd0);
    chk("wrap_ready", in_ready, 1'b0);
    step();
    check_clear("wrap_clear", 0, 100, 16'hF020);

    send(8'h1B);
    send(8'h3C);
    send(8'h51);
    chk("q_write", {ram_ce, ram_addr, ram_data}, {1'b1, 12'd0, 16'h3C51});
    send(8'h0C);
    chk("ff_first", {ram_ce, ram_addr, ram_data}, {1'b1, 12'd0, 16'h3C20});
    chk("ff_busy", {in_ready, busy}, 2'b01);
    repeat (49) step();
    chk("ff_mid_addr", ram_addr, 12'd49);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ce", ram_ce, 1'b0);
    chk("arst_cursor", {cur_row, cur_col}, 12'd0);
    chk("arst_ready_busy", {in_ready, busy}, 2'b01);
    repeat (2) step();
    reset = 1'b1;
    step();
    check_clear("reclear", 0, 3000, 16'hF020);
    chk("reclear_cursor", {cur_row, cur_col}, 12'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Character-stream console controller that owns the write port of the text RAM in the LCD text display. It accepts a byte stream over a valid/ready handshake, keeps the cursor position and the current colour attribute, and sequences all text RAM writes: single-cell writes, row clears and full-screen clears. The scan-out pipeline reads the other RAM port independently. This block never reads the RAM.

## Interface
- COLS, 100: characters per row (800 px / 8).
- ROWS, 30: rows per page (480 px / 16).
- DEFAULT_ATTR, 8'hF0: attribute after reset. [7:4] is the foreground palette index, [3:0] is the background index.
- clk_pix  in  1  pixel clock; the same clock drives the RAM write port (ram_clk = clk_pix).
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  byte available.
- in_data  in  8  byte: character or control code.
- in_ready  out  1  byte accepted on the same edge when in_valid=1.
- ram_ce  out  1  write strobe for the text RAM write port.
- ram_addr  out  12  cell address, computed as row*COLS+col.
- ram_data  out  16  cell value: {attr[7:0], 1'b0, glyph[6:0]}.
- cur_col  out  7  cursor column, range 0..COLS-1.
- cur_row  out  5  cursor row, range 0..ROWS-1.
- busy  out  1  high during a clear sequence.

## Operation
- States: CLR_ALL, IDLE, ESC, CLR_ROW.
- Reset:
  - ram_ce=0, ram_addr=0, ram_data=0, cur_col=0, cur_row=0, attr=DEFAULT_ATTR.
  - State is CLR_ALL; in_ready=0; busy=1.
- in_ready = 1 in IDLE and ESC only.
- A byte is accepted when in_valid && in_ready.
- IDLE, accepted byte:
  - 0x20..0x7E: write {attr, 0, byte[6:0]} at the cursor, then advance the cursor.
    - If col < COLS-1, col is incremented.
    - Otherwise the cursor performs a newline.
  - 0x0A (LF): newline.
  - 0x0D (CR): col=0.
  - 0x08 (BS): if col>0, col is decremented; the cell is not erased. At col 0 there is no change.
  - 0x0C (FF): go to CLR_ALL.
  - 0x1B (ESC): go to ESC.
  - Any other byte is consumed and ignored, with no write.
- ESC, accepted byte: attr=byte, then return to IDLE. No write, no cursor change.
- Newline:
  - col=0.
  - row increments; if row == ROWS-1, row becomes 0 (wrap to top, no scrolling).
  - Then go to CLR_ROW for the new row.
- CLR_ROW:
  - COLS consecutive writes of {attr, 8'h20}, covering the cells of the cursor row from column 0 to COLS-1.
  - Then return to IDLE.
- CLR_ALL:
  - ROWS*COLS consecutive writes of {attr, 8'h20} to addresses 0..ROWS*COLS-1.
  - Then set col=row=0 and return to IDLE.
- Address arithmetic:
  - A row_base register holds row*COLS. It is updated by +COLS, or reset to 0 on wrap. No multiplier is used.
  - ram_addr = row_base + col, truncated to 12 bits. The maximum value is 2999.
- busy = (state == CLR_ALL || state == CLR_ROW).

## Timing
- All outputs are registered.
- A printable byte accepted at edge N produces ram_ce=1 with its address and data during cycle N+1. The cursor shows the advanced value from N+1.
- Printable throughput is 1 byte per cycle with in_ready held high.
- ram_ce is 0 in every cycle without a write. ram_addr and ram_data hold their last value when ram_ce=0.
- Newline (LF or autowrap) accepted at edge N:
  - The autowrap cell write, if any, occurs in N+1.
  - The clear writes occupy N+1 .. N+COLS. For autowrap, the row clear starts the cycle after the cell write.
  - in_ready is low for the whole clear and returns high in the cycle after the last clear write.
- FF accepted at edge N: clear writes occupy ROWS*COLS cycles, with in_ready low throughout.
- Reset clear: CLR_ALL starts at the first edge after reset is released and gives 3000 writes with default parameters.
- Reset asserted mid-sequence:
  - Immediate return to the reset values, with ram_ce=0 asynchronously.
  - The partially cleared RAM is left as is; the full clear restarts after release.
- ESC followed by FF: 0x0C is taken as the attribute value. There is no clear.
- in_valid held while in_ready=0: the byte is not consumed and must be held by the source.

## Test plan
- Release reset and hold in_valid=0 → exactly 3000 ram_ce pulses with data 16'hF020 and addresses 0..2999 in order. busy drops, in_ready=1, cursor at (0,0).
- After init, stream "AB" back-to-back → writes (0,16'hF041) then (1,16'hF042) on consecutive cycles; cur_col=2.
- ESC, 0x1E, then "x" → one write 16'h1E78 at address 2. ESC and the attribute byte produce no writes.
- Send 100 printables on row 29 → the last cell write is at address 2999. It is followed by 100 clear writes to addresses 0..99, with cursor at (0,0) and in_ready low for those 100 cycles.
- CR at col 5 gives col 0. BS at col 0 gives no change. Byte 0x07 gives no write and no cursor change, and in_ready stays high.
- Assert reset 50 cycles into an FF clear → ram_ce drops immediately and the cursor is reset. After release, a full 3000-write clear is performed again with DEFAULT_ATTR.
